// File: rtl/inst_mem_loader_arb_pkg.sv
// -----------------------------------------------------------------------------
// inst_mem_loader_arb_pkg
// Shared definitions for the instruction-memory loader/arbiter:
//   - fallback values for the SoC-wide defines (CPU_WIDTH, INST_MEM_ADDR_DEPTH)
//   - 2-bit loader state encodings LDR_IDLE/LDR_RECV/LDR_WRITE/LDR_FLUSH
//   - ldr_state_e state type, datapath width and word geometry constants
// Optional feature macro used by the loader: INST_LOAD_TIMEOUT_EN.
// -----------------------------------------------------------------------------
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef INST_MEM_ADDR_DEPTH
`define INST_MEM_ADDR_DEPTH 1024
`endif
`ifndef LDR_IDLE
`define LDR_IDLE  2'd0
`endif
`ifndef LDR_RECV
`define LDR_RECV  2'd1
`endif
`ifndef LDR_WRITE
`define LDR_WRITE 2'd2
`endif
`ifndef LDR_FLUSH
`define LDR_FLUSH 2'd3
`endif

package inst_mem_loader_arb_pkg;

    localparam int unsigned XLEN           = `CPU_WIDTH;
    localparam int unsigned BYTES_PER_WORD = 4;
    // Word index width: byte address minus the two byte-offset bits.
    localparam int unsigned WIDX_W         = XLEN - 2;

    typedef enum logic [1:0] {
        S_IDLE  = `LDR_IDLE,
        S_RECV  = `LDR_RECV,
        S_WRITE = `LDR_WRITE,
        S_FLUSH = `LDR_FLUSH
    } ldr_state_e;

endpackage

// File: rtl/inst_mem_loader_arb_ldr_byte_pack.sv
// -----------------------------------------------------------------------------
// ldr_byte_pack
// Little-endian byte-to-word assembler for the program loader.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   clr_i         drop any partial word and restart at byte lane 0
//   byte_vld_i    a byte transfers this cycle (already qualified by ready)
//   byte_i        the byte
//   word_o        assembled word (lane 0 = first byte received)
//   word_vld_o    high in the cycle the 4th byte of a word transfers
// -----------------------------------------------------------------------------
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

module ldr_byte_pack
    import inst_mem_loader_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic        byte_vld_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_vld_o
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 2'd0;
        end else if (byte_vld_i) begin
            // Wraps to 0 after the 4th byte, ready for the next word.
            cnt_d = cnt_q + 2'd1;
        end
    end

    // Each lane captures only the byte whose arrival index matches it.
    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
        assign word_d[gi*8 +: 8] = clr_i                                ? 8'h00  :
                                   (byte_vld_i && (cnt_q == 2'(gi)))    ? byte_i :
                                                                          word_q[gi*8 +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 2'd0;
            word_q <= 32'd0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

    assign word_o     = word_q;
    assign word_vld_o = byte_vld_i && !clr_i && (cnt_q == 2'd3);

endmodule

// File: rtl/inst_mem_loader_arb.sv
// -----------------------------------------------------------------------------
// inst_mem_loader_arb
// Arbitrates the single address/write port of the instruction memory between
// core fetch and a byte-stream program loader. Loaded bytes are assembled
// little-endian into words and written at incrementing word addresses that
// wrap modulo MEM_DEPTH. The core is held for the whole load; a final FLUSH
// cycle re-reads core_pc_i so the memory's registered output is fresh when
// fetch resumes.
// Optional feature: define INST_LOAD_TIMEOUT_EN to abort a load (sticky
// load_err_o) after TIMEOUT_CYC consecutive RECV cycles without a byte.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   core_pc_i / core_hold_o         fetch address in, stall request out
//   core_inst_o / core_inst_vld_o   instruction passthrough and its valid
//   load_start_i/base_i/words_i     load command (start pulse, base, count)
//   byte_vld_i/byte_i/byte_rdy_o    RX byte handshake
//   load_busy_o/done_o/err_o        load status
//   mem_wr_en_o/addr_o/data_o       memory port, mem_inst_i read data
// -----------------------------------------------------------------------------
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef INST_MEM_ADDR_DEPTH
`define INST_MEM_ADDR_DEPTH 1024
`endif

module inst_mem_loader_arb
    import inst_mem_loader_arb_pkg::*;
#(
    parameter int unsigned MEM_DEPTH   = `INST_MEM_ADDR_DEPTH,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [`CPU_WIDTH-1:0] core_pc_i,
    output logic                  core_hold_o,
    output logic [`CPU_WIDTH-1:0] core_inst_o,
    output logic                  core_inst_vld_o,
    input  logic                  load_start_i,
    input  logic [`CPU_WIDTH-1:0] load_base_i,
    input  logic [CNT_W-1:0]      load_words_i,
    input  logic                  byte_vld_i,
    input  logic [7:0]            byte_i,
    output logic                  byte_rdy_o,
    output logic                  load_busy_o,
    output logic                  load_done_o,
    output logic                  load_err_o,
    output logic                  mem_wr_en_o,
    output logic [`CPU_WIDTH-1:0] mem_addr_o,
    output logic [`CPU_WIDTH-1:0] mem_data_o,
    input  logic [`CPU_WIDTH-1:0] mem_inst_i
);

    localparam logic [WIDX_W-1:0] LAST_WIDX = WIDX_W'(MEM_DEPTH - 1);

    ldr_state_e        state_q, state_d;
    logic [WIDX_W-1:0] addr_q,  addr_d;     // current load word index
    logic [CNT_W-1:0]  cnt_q,   cnt_d;      // words still to write
    logic              err_q,   err_d;
    logic              ivld_q,  ivld_d;

    logic              xfer;
    logic              pack_clr;
    logic [31:0]       pack_word;
    logic              pack_word_vld;

`ifdef INST_LOAD_TIMEOUT_EN
    localparam int unsigned   TO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

    // Ready depends only on state so the handshake never loops through the FSM.
    assign byte_rdy_o = (state_q == S_RECV);
    assign xfer       = byte_vld_i && byte_rdy_o;

    ldr_byte_pack u_byte_pack (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (pack_clr),
        .byte_vld_i (xfer),
        .byte_i     (byte_i),
        .word_o     (pack_word),
        .word_vld_o (pack_word_vld)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        pack_clr    = 1'b0;
        core_hold_o = 1'b0;
        load_busy_o = 1'b0;
        load_done_o = 1'b0;
        mem_wr_en_o = 1'b0;
        mem_addr_o  = core_pc_i;
`ifdef INST_LOAD_TIMEOUT_EN
        // Idle counter only runs in RECV; any other state (including the
        // WRITE that precedes re-entry) leaves it cleared.
        to_cnt_d    = '0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (load_start_i) begin
                    addr_d   = load_base_i[`CPU_WIDTH-1:2];
                    cnt_d    = load_words_i;
                    err_d    = 1'b0;
                    pack_clr = 1'b1;
                    state_d  = (load_words_i == '0) ? S_FLUSH : S_RECV;
                end
            end
            S_RECV: begin
                core_hold_o = 1'b1;
                load_busy_o = 1'b1;
                mem_addr_o  = {addr_q, 2'b00};
                if (pack_word_vld) begin
                    state_d = S_WRITE;
                end
`ifdef INST_LOAD_TIMEOUT_EN
                else if (!xfer) begin
                    if (to_cnt_q == TO_LAST) begin
                        err_d    = 1'b1;
                        pack_clr = 1'b1;
                        state_d  = S_FLUSH;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
`endif
            end
            S_WRITE: begin
                core_hold_o = 1'b1;
                load_busy_o = 1'b1;
                mem_wr_en_o = 1'b1;
                mem_addr_o  = {addr_q, 2'b00};
                addr_d      = (addr_q >= LAST_WIDX) ? '0 : addr_q + 1'b1;
                cnt_d       = cnt_q - 1'b1;
                state_d     = (cnt_q == CNT_W'(1)) ? S_FLUSH : S_RECV;
            end
            S_FLUSH: begin
                // mem_addr_o stays on core_pc_i: this read refreshes mem_inst_i.
                core_hold_o = 1'b1;
                load_busy_o = 1'b1;
                load_done_o = !err_q;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Read data is valid for the core only if the read issued last cycle was
    // driven by core_pc_i.
    assign ivld_d = (state_q == S_IDLE) || (state_q == S_FLUSH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            ivld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ivld_q  <= ivld_d;
        end
    end

`ifdef INST_LOAD_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`endif

    assign core_inst_o     = mem_inst_i;
    assign core_inst_vld_o = ivld_q;
    assign load_err_o      = err_q;
    assign mem_data_o      = `CPU_WIDTH'(pack_word);

    // Byte-offset bits of the base are ignored; the timeout limit is only
    // consumed when the timeout logic is built.
`ifdef INST_LOAD_TIMEOUT_EN
    logic unused_ok;
    assign unused_ok = ^{1'b0, load_base_i[1:0]};
`else
    localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYC);
    logic unused_ok;
    assign unused_ok = ^{1'b0, load_base_i[1:0], TIMEOUT_LIM[0]};
`endif

endmodule

// File: tb/tb_inst_mem_loader_arb.sv
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

module tb_inst_mem_loader_arb;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] core_pc_i;
    logic        core_hold_o;
    logic [31:0] core_inst_o;
    logic        core_inst_vld_o;
    logic        load_start_i;
    logic [31:0] load_base_i;
    logic [15:0] load_words_i;
    logic        byte_vld_i;
    logic [7:0]  byte_i;
    logic        byte_rdy_o;
    logic        load_busy_o;
    logic        load_done_o;
    logic        load_err_o;
    logic        mem_wr_en_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_inst_i;

    int n_checks = 0;
    int n_errors = 0;

    inst_mem_loader_arb #(
        .MEM_DEPTH   (DEPTH),
        .CNT_W       (16),
        .TIMEOUT_CYC (20)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .core_pc_i       (core_pc_i),
        .core_hold_o     (core_hold_o),
        .core_inst_o     (core_inst_o),
        .core_inst_vld_o (core_inst_vld_o),
        .load_start_i    (load_start_i),
        .load_base_i     (load_base_i),
        .load_words_i    (load_words_i),
        .byte_vld_i      (byte_vld_i),
        .byte_i          (byte_i),
        .byte_rdy_o      (byte_rdy_o),
        .load_busy_o     (load_busy_o),
        .load_done_o     (load_done_o),
        .load_err_o      (load_err_o),
        .mem_wr_en_o     (mem_wr_en_o),
        .mem_addr_o      (mem_addr_o),
        .mem_data_o      (mem_data_o),
        .mem_inst_i      (mem_inst_i)
    );

    always #5 clk = ~clk;

    // Instruction memory model: synchronous write, registered read.
    logic [31:0] mem_model [DEPTH];
    logic [31:0] mem_rd_q;
    always @(posedge clk) begin
        if (mem_wr_en_o) mem_model[mem_addr_o[7:2]] <= mem_data_o;
        mem_rd_q <= mem_model[mem_addr_o[7:2]];
    end
    assign mem_inst_i = mem_rd_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        start;
        logic [31:0] base;
        logic [15:0] words;
        logic        bvld;
        logic [7:0]  bdat;
        logic [31:0] pc;
        logic        e_wr;
        logic [31:0] e_addr;
        logic [31:0] e_data;
        logic        e_hold;
        logic        e_rdy;
        logic        e_done;
        logic        e_ivld;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic [31:0] base, input logic [15:0] words,
                                input logic bv, input logic [7:0] bd, input logic [31:0] pc,
                                input logic wr, input logic [31:0] ea, input logic [31:0] ed,
                                input logic h, input logic r, input logic d, input logic iv);
        vec_t v;
        v.start = st; v.base = base; v.words = words; v.bvld = bv; v.bdat = bd; v.pc = pc;
        v.e_wr = wr; v.e_addr = ea; v.e_data = ed; v.e_hold = h; v.e_rdy = r; v.e_done = d;
        v.e_ivld = iv;
        return v;
    endfunction

    // Randomized load checked against a reference built from the byte stream:
    // word k = bytes 4k..4k+3 little-endian, at ((base/4 + k) mod DEPTH) * 4.
    task automatic do_load(input logic [31:0] base, input int nwords, input int vld_pct,
                           input bit glitch);
        logic [7:0]  rx[$];
        logic [31:0] exp_a, exp_d;
        int writes = 0;
        int dones = 0;
        int gap = 0;
        bit finished = 0;
        $display("load base=0x%08h words=%0d vld_pct=%0d glitch=%0d", base, nwords, vld_pct, glitch);
        load_start_i = 1'b1; load_base_i = base; load_words_i = 16'(nwords); byte_vld_i = 1'b0;
        #1;
        chk("ld_idle_hold", 32'(core_hold_o), 32'd0);
        step();
        load_start_i = 1'b0;
        for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
            load_start_i = 1'b0;
            byte_vld_i   = 1'b0;
            if (rx.size() < nwords * 4)
                byte_vld_i = ($urandom_range(0, 99) < vld_pct) || (gap >= 5);
            byte_i = 8'($urandom_range(0, 255));
            if (glitch && rx.size() == 2 && byte_rdy_o) begin
                load_start_i = 1'b1; load_base_i = 32'h80; load_words_i = 16'd5;
            end
            #1;
            if (mem_wr_en_o) begin
                exp_a = 32'((((base >> 2) + writes) % DEPTH) * 4);
                exp_d = 32'hDEAD_0000;
                if (rx.size() >= writes * 4 + 4)
                    exp_d = {rx[writes*4+3], rx[writes*4+2], rx[writes*4+1], rx[writes*4]};
                $display("write addr=0x%08h data=0x%08h", mem_addr_o, mem_data_o);
                if (writes >= nwords) chk("ld_extra_write", 32'(writes + 1), 32'(nwords));
                chk("ld_wr_addr", mem_addr_o, exp_a);
                chk("ld_wr_data", mem_data_o, exp_d);
                writes++;
            end
            if (rx.size() < nwords * 4) begin
                if (byte_vld_i && byte_rdy_o) begin
                    rx.push_back(byte_i);
                    gap = 0;
                end else begin
                    gap++;
                end
            end
            if (load_done_o) begin
                dones++;
                chk("ld_writes_at_done", 32'(writes), 32'(nwords));
                chk("ld_bytes_at_done", 32'(rx.size()), 32'(nwords * 4));
                finished = 1;
            end
            step();
        end
        chk("ld_done_seen", 32'(dones), 32'd1);
        chk("ld_hold_released", 32'(core_hold_o), 32'd0);
        chk("ld_busy_released", 32'(load_busy_o), 32'd0);
        load_start_i = 1'b0;
        byte_vld_i   = 1'b0;
    endtask

    vec_t vt[$];

    initial begin
        rst_n = 1'b0; core_pc_i = 32'h8; load_start_i = 1'b0; load_base_i = 32'h0;
        load_words_i = 16'h0; byte_vld_i = 1'b0; byte_i = 8'h0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold", 32'(core_hold_o), 32'd0);
        chk("rst_busy", 32'(load_busy_o), 32'd0);
        chk("rst_ivld", 32'(core_inst_vld_o), 32'd0);
        chk("rst_wr", 32'(mem_wr_en_o), 32'd0);
        chk("rst_data", mem_data_o, 32'd0);
        chk("rst_addr_pc", mem_addr_o, 32'h8);
        rst_n = 1'b1;
        step();

        // ---------------- table-driven directed vectors ----------------
        //        st base  wds bv bd     pc     wr ea     ed            h  r  d  iv
        vt.push_back(mk(0, 0,     0, 1, 8'hEE, 32'h8,  0, 32'h8,  0,            0, 0, 0, 1)); // byte in IDLE not taken
        vt.push_back(mk(1, 32'h10,1, 1, 8'hEE, 32'h8,  0, 32'h8,  0,            0, 0, 0, 1)); // start
        vt.push_back(mk(0, 0,     0, 1, 8'h13, 32'h8,  0, 32'h10, 0,            1, 1, 0, 1));
        vt.push_back(mk(0, 0,     0, 1, 8'h05, 32'h8,  0, 32'h10, 0,            1, 1, 0, 0));
        vt.push_back(mk(0, 0,     0, 1, 8'h10, 32'h8,  0, 32'h10, 0,            1, 1, 0, 0));
        vt.push_back(mk(0, 0,     0, 1, 8'h00, 32'h8,  0, 32'h10, 0,            1, 1, 0, 0));
        vt.push_back(mk(0, 0,     0, 0, 8'h00, 32'h8,  1, 32'h10, 32'h00100513, 1, 0, 0, 0)); // WRITE
        vt.push_back(mk(1, 32'h40,1, 0, 8'h00, 32'h8,  0, 32'h8,  0,            1, 0, 1, 0)); // FLUSH, start ignored
        vt.push_back(mk(0, 0,     0, 0, 8'h00, 32'h8,  0, 32'h8,  0,            0, 0, 0, 1)); // IDLE
        vt.push_back(mk(1, 32'h0, 0, 0, 8'h00, 32'h8,  0, 32'h8,  0,            0, 0, 0, 1)); // words 0
        vt.push_back(mk(0, 0,     0, 0, 8'h00, 32'h8,  0, 32'h8,  0,            1, 0, 1, 1)); // FLUSH, no write
        vt.push_back(mk(0, 0,     0, 0, 8'h00, 32'h8,  0, 32'h8,  0,            0, 0, 0, 1));
        vt.push_back(mk(1, 32'h13,1, 0, 8'h00, 32'h20, 0, 32'h20, 0,            0, 0, 0, 1)); // base 0x13
        vt.push_back(mk(0, 0,     0, 1, 8'h78, 32'h20, 0, 32'h10, 0,            1, 1, 0, 1));
        vt.push_back(mk(0, 0,     0, 1, 8'h56, 32'h20, 0, 32'h10, 0,            1, 1, 0, 0));
        vt.push_back(mk(0, 0,     0, 1, 8'h34, 32'h20, 0, 32'h10, 0,            1, 1, 0, 0));
        vt.push_back(mk(0, 0,     0, 1, 8'h12, 32'h20, 0, 32'h10, 0,            1, 1, 0, 0));
        vt.push_back(mk(0, 0,     0, 0, 8'h00, 32'h20, 1, 32'h10, 32'h12345678, 1, 0, 0, 0));
        vt.push_back(mk(0, 0,     0, 0, 8'h00, 32'h20, 0, 32'h20, 0,            1, 0, 1, 0));
        vt.push_back(mk(0, 0,     0, 0, 8'h00, 32'h10, 0, 32'h10, 0,            0, 0, 0, 1));

        foreach (vt[i]) begin
            load_start_i = vt[i].start; load_base_i = vt[i].base; load_words_i = vt[i].words;
            byte_vld_i = vt[i].bvld; byte_i = vt[i].bdat; core_pc_i = vt[i].pc;
            #1;
            $display("vec %0d: wr=%0d addr=0x%08h hold=%0d rdy=%0d done=%0d ivld=%0d",
                     i, mem_wr_en_o, mem_addr_o, core_hold_o, byte_rdy_o, load_done_o, core_inst_vld_o);
            chk($sformatf("vec%0d_wr", i),   32'(mem_wr_en_o),     32'(vt[i].e_wr));
            chk($sformatf("vec%0d_addr", i), mem_addr_o,           vt[i].e_addr);
            if (vt[i].e_wr) chk($sformatf("vec%0d_data", i), mem_data_o, vt[i].e_data);
            chk($sformatf("vec%0d_hold", i), 32'(core_hold_o),     32'(vt[i].e_hold));
            chk($sformatf("vec%0d_busy", i), 32'(load_busy_o),     32'(vt[i].e_hold));
            chk($sformatf("vec%0d_rdy", i),  32'(byte_rdy_o),      32'(vt[i].e_rdy));
            chk($sformatf("vec%0d_done", i), 32'(load_done_o),     32'(vt[i].e_done));
            chk($sformatf("vec%0d_ivld", i), 32'(core_inst_vld_o), 32'(vt[i].e_ivld));
            chk($sformatf("vec%0d_err", i),  32'(load_err_o),      32'd0);
            step();
        end
        load_start_i = 1'b0; byte_vld_i = 1'b0;

        // Fetch after load: pc 0x10 was read last cycle, holds the loaded word.
        chk("fetch_inst", core_inst_o, 32'h12345678);
        chk("fetch_ivld", 32'(core_inst_vld_o), 32'd1);

        // ---------------- randomized loads ----------------
        do_load(32'h0, 3, 60, 1'b0);
        do_load(32'((DEPTH - 1) * 4), 2, 80, 1'b0);
        for (int k = 0; k < 4; k++) begin
            do_load(32'($urandom_range(0, 255)), $urandom_range(1, 4), $urandom_range(50, 100), 1'b0);
        end

        // ---------------- reset mid-load ----------------
        load_start_i = 1'b1; load_base_i = 32'h20; load_words_i = 16'd3;
        #1;
        step();
        load_start_i = 1'b0;
        for (int b = 0; b < 6; b++) begin
            byte_vld_i = 1'b1; byte_i = 8'(b + 1);
            #1;
            step();
        end
        core_pc_i = 32'h44;
        #1;
        chk("mid_hold_before_rst", 32'(core_hold_o), 32'd1);
        rst_n = 1'b0;
        #1;
        $display("reset asserted mid-load");
        chk("mid_rst_hold", 32'(core_hold_o), 32'd0);
        chk("mid_rst_busy", 32'(load_busy_o), 32'd0);
        chk("mid_rst_rdy", 32'(byte_rdy_o), 32'd0);
        chk("mid_rst_wr", 32'(mem_wr_en_o), 32'd0);
        chk("mid_rst_done", 32'(load_done_o), 32'd0);
        chk("mid_rst_err", 32'(load_err_o), 32'd0);
        chk("mid_rst_ivld", 32'(core_inst_vld_o), 32'd0);
        chk("mid_rst_data", mem_data_o, 32'd0);
        chk("mid_rst_addr", mem_addr_o, 32'h44);
        step();
        rst_n = 1'b1; byte_vld_i = 1'b0;
        step();
        chk("post_rst_ivld", 32'(core_inst_vld_o), 32'd1);
        do_load(32'h40, 2, 70, 1'b1);

`ifdef INST_LOAD_TIMEOUT_EN
        // ---------------- inter-byte timeout ----------------
        $display("timeout load");
        load_start_i = 1'b1; load_base_i = 32'h30; load_words_i = 16'd1;
        #1;
        step();
        load_start_i = 1'b0;
        for (int b = 0; b < 2; b++) begin
            byte_vld_i = 1'b1; byte_i = 8'hA0 + 8'(b);
            #1;
            step();
        end
        byte_vld_i = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            #1;
            chk($sformatf("to_wait%0d_rdy", c), 32'(byte_rdy_o), 32'd1);
            chk($sformatf("to_wait%0d_err", c), 32'(load_err_o), 32'd0);
            chk($sformatf("to_wait%0d_wr", c),  32'(mem_wr_en_o), 32'd0);
            step();
        end
        chk("to_err_set", 32'(load_err_o), 32'd1);
        chk("to_flush_hold", 32'(core_hold_o), 32'd1);
        chk("to_no_done", 32'(load_done_o), 32'd0);
        chk("to_no_wr", 32'(mem_wr_en_o), 32'd0);
        step();
        chk("to_idle_hold", 32'(core_hold_o), 32'd0);
        chk("to_err_sticky", 32'(load_err_o), 32'd1);
        load_start_i = 1'b1; load_base_i = 32'h0; load_words_i = 16'd0;
        #1;
        step();
        load_start_i = 1'b0;
        chk("to_err_cleared", 32'(load_err_o), 32'd0);
        chk("to_zero_done", 32'(load_done_o), 32'd1);
        step();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/inst_mem_loader_arb.md
Name: inst_mem_loader_arb

Overview:
- Owns the single address/write port of the instruction memory and arbitrates it between core instruction fetch and a byte-stream program loader (UART/debug RX).
- Assembles little-endian bytes into 32-bit words and writes them at incrementing word addresses.
- Holds the core while a load is in progress, then hands the port back to fetch.
- Sits between the core fetch stage, the RX byte source and the instruction memory in the SoC perips layer.

Parameters:
- MEM_DEPTH, default `INST_MEM_ADDR_DEPTH: instruction memory depth in words; load addresses wrap modulo this depth.
- CNT_W, default 16: width of the load word-count input.
- TIMEOUT_CYC, default 65535: inter-byte idle limit in clocks. Used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- core_pc_i  in  `CPU_WIDTH  core fetch byte address
- core_hold_o  out  1  stall request to core; 1 while the loader owns memory
- core_inst_o  out  `CPU_WIDTH  instruction to core, passed through from mem_inst_i
- core_inst_vld_o  out  1  core_inst_o corresponds to a core-owned read issued last cycle
- load_start_i  in  1  single-cycle pulse that starts a load
- load_base_i  in  `CPU_WIDTH  load start byte address; bits [1:0] ignored
- load_words_i  in  CNT_W  number of 32-bit words to load
- byte_vld_i  in  1  RX byte valid
- byte_i  in  8  RX byte
- byte_rdy_o  out  1  loader accepts a byte
- load_busy_o  out  1  load in progress
- load_done_o  out  1  one-cycle pulse on successful completion
- load_err_o  out  1  sticky error flag; cleared by the next accepted load_start_i
- mem_wr_en_o  out  1  memory write enable
- mem_addr_o  out  `CPU_WIDTH  memory byte address
- mem_data_o  out  `CPU_WIDTH  memory write data
- mem_inst_i  in  `CPU_WIDTH  memory registered read data, 1-cycle latency

Behaviour:
- Reset values:
  - state = IDLE.
  - All 1-bit outputs = 0.
  - mem_data_o = 0. The internal byte shift register and word counter clear to 0.
  - A reset mid-load abandons the load. Words already written stay in memory; no done or err pulse is produced.
- FSM states: IDLE, RECV, WRITE, FLUSH.
- IDLE:
  - mem_addr_o = core_pc_i; mem_wr_en_o = 0; core_hold_o = 0.
  - load_start_i: latch base {load_base_i[31:2], 2'b00}, latch count = load_words_i, clear load_err_o.
  - If count = 0, go to FLUSH with no write. Otherwise go to RECV.
- RECV:
  - byte_rdy_o = 1. A byte transfers when byte_vld_i & byte_rdy_o.
  - Bytes shift into word bits [7:0], [15:8], [23:16], [31:24] in arrival order, tracked by a 2-bit byte counter.
  - On the 4th transfer, go to WRITE.
- WRITE (exactly one cycle):
  - mem_wr_en_o = 1; mem_addr_o = current load address; mem_data_o = assembled word.
  - Then advance the word address by 4, wrapping at MEM_DEPTH*4, and decrement the count.
  - If the remaining count is 0, go to FLUSH; otherwise go to RECV.
- FLUSH (one cycle):
  - core_hold_o = 1 still asserted; mem_addr_o = core_pc_i, a re-read that refreshes the memory's registered output.
  - Then go to IDLE. load_done_o pulses in this cycle unless load_err_o was set during this load.
- Signals asserted during a load:
  - core_hold_o = 1 and load_busy_o = 1 in RECV, WRITE and FLUSH.
  - mem_addr_o = load address in RECV.
- core_inst_o always equals mem_inst_i.
- core_inst_vld_o is registered: it equals 1 iff the previous cycle was IDLE or FLUSH.
- load_start_i outside IDLE is ignored; no error is raised.
- Byte offered while in IDLE: byte_rdy_o = 0, so the byte is not consumed.

Optional Feature:
- Macro: INST_LOAD_TIMEOUT_EN.
- With the macro defined:
  - A counter counts cycles in RECV without a byte transfer.
  - When the counter reaches TIMEOUT_CYC, set load_err_o, discard the partial word and go to FLUSH. No load_done_o pulse is produced.
  - The counter is cleared on every transfer and on RECV entry.
- Without the macro: no counter is built and RECV waits indefinitely.

Decomposition:
- Shared defines (rooth_defines): `CPU_WIDTH, `INST_MEM_ADDR_DEPTH, and the state encodings LDR_IDLE/LDR_RECV/LDR_WRITE/LDR_FLUSH (2-bit).
- One natural sub-module, ldr_byte_pack:
  - Contains the byte counter and the 32-bit shift register.
  - Outputs word_o and word_vld_o, the latter on the 4th byte.

Test Plan:
- Fetch passthrough: no load, core_pc_i = 0x8 -> mem_addr_o = 0x8, mem_wr_en_o = 0, core_inst_vld_o = 1 from the cycle after reset release.
- Single-word load: base 0x10, words 1, bytes 0x13,0x05,0x10,0x00 -> one WRITE cycle with addr 0x10, data 0x00100513. Then FLUSH, then load_done_o pulse; core_hold_o = 0 on the next cycle.
- Multi-word with gaps: words 3, random byte_vld_i gaps -> writes at 0x0, 0x4, 0x8 in order, and no byte is lost or duplicated.
- Boundary conditions:
  - Words 0: IDLE -> FLUSH -> IDLE, done pulse, no write.
  - Base 0x13: first write at 0x10.
  - Base (MEM_DEPTH-1)*4, words 2: second write lands at 0x0.
- Reset mid-load after 6 bytes -> all outputs return to reset values and the state is IDLE. A fresh load afterwards behaves correctly, and a load_start_i during RECV is ignored.
- INST_LOAD_TIMEOUT_EN with TIMEOUT_CYC = 20: stop bytes after byte 2 -> load_err_o = 1 at cycle 20, no write, no done pulse, then IDLE.
